// File: rtl/cram_chain_loader.sv
// Word-parallel CRAM chain loader: streams config words into NUM_CHAINS lock-step
// chains (LOAD) or recirculates them while emitting their contents (READBACK).
module cram_chain_loader #(
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned CHAIN_LEN  = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  config_en,
  output logic [NUM_CHAINS-1:0] config_data_in,
  input  logic [NUM_CHAINS-1:0] config_data_out,
  output logic                  le_nrst,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BEATS  = DATA_WIDTH / NUM_CHAINS;
  localparam int unsigned WORDS  = (CHAIN_LEN * NUM_CHAINS) / DATA_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t                  state;
  logic                    mode_q;
  logic                    cfg_valid;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [WORD_W-1:0]       word_cnt;
  logic [DATA_WIDTH-1:0]   sreg;
  logic [DATA_WIDTH-1:0]   capture;
  logic [NUM_CHAINS-1:0]   load_lane;
  logic [DATA_WIDTH-1:0]   cap_next;

  // Beat-indexed lane select for LOAD and capture-with-current-tails for READBACK.
  always_comb begin
    load_lane = '0;
    cap_next  = capture;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (beat_cnt == BEAT_W'(k)) begin
        load_lane                          = sreg[k*NUM_CHAINS +: NUM_CHAINS];
        cap_next[k*NUM_CHAINS +: NUM_CHAINS] = config_data_out;
      end
    end
  end

  // Chain-facing strobes are decodes of registered state so the heads see
  // the tails in the same cycle during recirculation.
  assign config_en      = en && (state == ST_SHIFT);
  assign in_ready       = en && (state == ST_FETCH);
  assign config_data_in = (state != ST_SHIFT) ? '0 :
                          (mode_q ? config_data_out : load_lane);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      mode_q    <= 1'b0;
      cfg_valid <= 1'b0;
      beat_cnt  <= '0;
      word_cnt  <= '0;
      sreg      <= '0;
      capture   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      le_nrst   <= 1'b0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          le_nrst <= cfg_valid;
          if (start) begin
            mode_q  <= mode;
            le_nrst <= 1'b0;
            state   <= mode ? ST_SHIFT : ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (in_valid) begin
            sreg  <= in_data;
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (mode_q) begin
            capture <= cap_next;
          end
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
            if (mode_q) begin
              out_data  <= cap_next;
              out_valid <= 1'b1;
              state     <= ST_EMIT;
            end else if (word_cnt == LAST_WORD) begin
              state <= ST_DONE;
            end else begin
              word_cnt <= word_cnt + WORD_W'(1);
              state    <= ST_FETCH;
            end
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end

        // Word held on out_data until the consumer takes it; chains stay still.
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (word_cnt == LAST_WORD) begin
              state <= ST_DONE;
            end else begin
              word_cnt <= word_cnt + WORD_W'(1);
              state    <= ST_SHIFT;
            end
          end
        end

        ST_DONE: begin
          beat_cnt <= '0;
          word_cnt <= '0;
          if (!mode_q) begin
            cfg_valid <= 1'b1;
          end
          le_nrst <= cfg_valid | ~mode_q;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
